// File: rtl/mmu_memory_arbiter_pkg.sv
// Shared definitions for the MMU memory arbiter: requester IDs, default tag depth, arbiter states.
package mmu_memory_arbiter_pkg;

    localparam int TAG_DEPTH_DEFAULT   = 8;
    localparam int TAG_DEPTH_N_DEFAULT = 3;

    typedef enum logic {
        RQ_INST = 1'b0,
        RQ_DATA = 1'b1
    } rq_id_e;

    typedef enum logic {
        ARB_OPEN = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic logic [1:0] rq_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mmu_memory_arbiter_tag_fifo.sv
// In-order tag FIFO of requester IDs for outstanding memory requests.
module mmu_memory_arbiter_tag_fifo
    import mmu_memory_arbiter_pkg::*;
#(
    parameter int P_TAG_DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int P_TAG_DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   push,
    input  logic                   push_id,
    input  logic                   pop,
    output logic                   head_id,
    output logic                   full,
    output logic                   empty,
    output logic [P_TAG_DEPTH_N:0] count
);

    localparam logic [P_TAG_DEPTH_N:0] DEPTH_C = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

    logic [P_TAG_DEPTH-1:0]   mem_q;
    logic [P_TAG_DEPTH_N-1:0] wr_ptr_q;
    logic [P_TAG_DEPTH_N-1:0] rd_ptr_q;
    logic [P_TAG_DEPTH_N:0]   count_q;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    // A pop frees the head slot, so a push into a full FIFO is fine in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmu_memory_arbiter.sv
// Two-requester (instruction/data MMU) memory arbiter with in-order response routing.
// Define MMU_MEMORY_ARBITER_RR_EN for round-robin tie-break; default is fixed data priority.
//
//  state    | meaning
//  ARB_OPEN | no pending stalled grant; arbitrate freely
//  ARB_HOLD | last grant was stalled by memory; re-grant hold_id_q unchanged
module mmu_memory_arbiter
    import mmu_memory_arbiter_pkg::*;
#(
    parameter int P_TAG_DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int P_TAG_DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic [1:0]  iRQ_REQ,
    output logic [1:0]  oRQ_LOCK,
    input  logic [3:0]  iRQ_ORDER,
    input  logic [1:0]  iRQ_RW,
    input  logic [63:0] iRQ_ADDR,
    input  logic [63:0] iRQ_DATA,
    output logic [1:0]  oRQ_VALID,
    output logic [63:0] oRQ_DATA,
    output logic        oMEMORY_REQ,
    input  logic        iMEMORY_LOCK,
    output logic [1:0]  oMEMORY_ORDER,
    output logic        oMEMORY_RW,
    output logic [31:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_VALID,
    input  logic [63:0] iMEMORY_DATA,
    output logic        oPROTOCOL_ERR
);

    localparam logic [P_TAG_DEPTH_N:0] DEPTH_C = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

    arb_state_e             state_q, state_d;
    logic                   hold_id_q, hold_id_d;
    logic                   grant_valid;
    logic                   grant_id;
    logic                   tie_winner;
    logic                   accept;
    logic                   resp_pop;
    logic                   tag_head;
    logic                   tag_full;
    logic                   tag_empty;
    logic [P_TAG_DEPTH_N:0] tag_count;
    logic                   err_q;

`ifdef MMU_MEMORY_ARBITER_RR_EN
    logic rr_last_q;

    assign tie_winner = ~rr_last_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rr_last_q <= RQ_INST;
        end else if (accept) begin
            rr_last_q <= grant_id;
        end
    end
`else
    assign tie_winner = RQ_DATA;
`endif

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= ARB_OPEN;
            hold_id_q <= RQ_INST;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = RQ_INST;
        state_d     = ARB_OPEN;
        hold_id_d   = hold_id_q;
        // Grant uses the pre-pop full flag; a same-cycle response does not open a slot.
        if (!tag_full) begin
            if (state_q == ARB_HOLD && iRQ_REQ[hold_id_q]) begin
                grant_valid = 1'b1;
                grant_id    = hold_id_q;
            end else if (iRQ_REQ == 2'b11) begin
                grant_valid = 1'b1;
                grant_id    = tie_winner;
            end else if (iRQ_REQ[1]) begin
                grant_valid = 1'b1;
                grant_id    = RQ_DATA;
            end else if (iRQ_REQ[0]) begin
                grant_valid = 1'b1;
                grant_id    = RQ_INST;
            end
        end
        if (grant_valid && iMEMORY_LOCK) begin
            state_d   = ARB_HOLD;
            hold_id_d = grant_id;
        end
    end

    assign oMEMORY_REQ   = inRESET && grant_valid;
    assign oMEMORY_ORDER = grant_id ? iRQ_ORDER[3:2]  : iRQ_ORDER[1:0];
    assign oMEMORY_RW    = grant_id ? iRQ_RW[1]       : iRQ_RW[0];
    assign oMEMORY_ADDR  = grant_id ? iRQ_ADDR[63:32] : iRQ_ADDR[31:0];
    assign oMEMORY_DATA  = grant_id ? iRQ_DATA[63:32] : iRQ_DATA[31:0];

    assign accept = oMEMORY_REQ && !iMEMORY_LOCK;

    always_comb begin
        oRQ_LOCK = 2'b00;
        if (inRESET) begin
            oRQ_LOCK[0] = iMEMORY_LOCK || tag_full || (grant_valid && grant_id == RQ_DATA);
            oRQ_LOCK[1] = iMEMORY_LOCK || tag_full || (grant_valid && grant_id == RQ_INST);
        end
    end

    assign resp_pop  = inRESET && iMEMORY_VALID && !tag_empty;
    assign oRQ_VALID = resp_pop ? rq_onehot(tag_head) : 2'b00;
    assign oRQ_DATA  = iMEMORY_DATA;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            err_q <= 1'b0;
        end else if (iMEMORY_VALID && tag_empty) begin
            err_q <= 1'b1;
        end
    end

    assign oPROTOCOL_ERR = err_q;

    mmu_memory_arbiter_tag_fifo #(
        .P_TAG_DEPTH   (P_TAG_DEPTH),
        .P_TAG_DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .push    (accept),
        .push_id (grant_id),
        .pop     (resp_pop),
        .head_id (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    a_count_full : assert property (@(posedge iCLOCK) disable iff (!inRESET)
        (tag_count <= DEPTH_C) && (tag_full == (tag_count == DEPTH_C)));

endmodule

// File: tb/tb_mmu_memory_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle plus directed literal checks.
module tb_mmu_memory_arbiter;

    localparam int DEPTH = 8;

    logic        iCLOCK;
    logic        inRESET;
    logic [1:0]  iRQ_REQ;
    logic [1:0]  oRQ_LOCK;
    logic [3:0]  iRQ_ORDER;
    logic [1:0]  iRQ_RW;
    logic [63:0] iRQ_ADDR;
    logic [63:0] iRQ_DATA;
    logic [1:0]  oRQ_VALID;
    logic [63:0] oRQ_DATA;
    logic        oMEMORY_REQ;
    logic        iMEMORY_LOCK;
    logic [1:0]  oMEMORY_ORDER;
    logic        oMEMORY_RW;
    logic [31:0] oMEMORY_ADDR;
    logic [31:0] oMEMORY_DATA;
    logic        iMEMORY_VALID;
    logic [63:0] iMEMORY_DATA;
    logic        oPROTOCOL_ERR;

    int total = 0;
    int bad   = 0;

    mmu_memory_arbiter #(.P_TAG_DEPTH(DEPTH), .P_TAG_DEPTH_N(3)) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iRQ_REQ       (iRQ_REQ),
        .oRQ_LOCK      (oRQ_LOCK),
        .iRQ_ORDER     (iRQ_ORDER),
        .iRQ_RW        (iRQ_RW),
        .iRQ_ADDR      (iRQ_ADDR),
        .iRQ_DATA      (iRQ_DATA),
        .oRQ_VALID     (oRQ_VALID),
        .oRQ_DATA      (oRQ_DATA),
        .oMEMORY_REQ   (oMEMORY_REQ),
        .iMEMORY_LOCK  (iMEMORY_LOCK),
        .oMEMORY_ORDER (oMEMORY_ORDER),
        .oMEMORY_RW    (oMEMORY_RW),
        .oMEMORY_ADDR  (oMEMORY_ADDR),
        .oMEMORY_DATA  (oMEMORY_DATA),
        .iMEMORY_VALID (iMEMORY_VALID),
        .iMEMORY_DATA  (iMEMORY_DATA),
        .oPROTOCOL_ERR (oPROTOCOL_ERR)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requester IDs in order, stalled grant, last accepted requester.
    int q[$];
    bit err_m   = 1'b0;
    bit hold_v  = 1'b0;
    bit hold_id = 1'b0;
    bit last_m  = 1'b0;

    function automatic void model_grant(output bit gv, output bit gid);
        bit tie;
`ifdef MMU_MEMORY_ARBITER_RR_EN
        tie = !last_m;
`else
        tie = 1'b1;
`endif
        gv  = 1'b0;
        gid = 1'b0;
        if (q.size() < DEPTH) begin
            if (hold_v && iRQ_REQ[hold_id]) begin gv = 1'b1; gid = hold_id; end
            else if (iRQ_REQ == 2'b11)      begin gv = 1'b1; gid = tie; end
            else if (iRQ_REQ[1])            begin gv = 1'b1; gid = 1'b1; end
            else if (iRQ_REQ[0])            begin gv = 1'b1; gid = 1'b0; end
        end
    endfunction

    always @(posedge iCLOCK or negedge inRESET) begin
        bit gv, gid;
        if (!inRESET) begin
            q.delete();
            err_m  = 1'b0;
            hold_v = 1'b0;
            last_m = 1'b0;
        end else begin
            model_grant(gv, gid);
            if (iMEMORY_VALID) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1'b1;
            end
            if (gv && !iMEMORY_LOCK) begin
                q.push_back(int'(gid));
                last_m = gid;
            end
            hold_v  = gv && iMEMORY_LOCK;
            hold_id = gid;
        end
    end

    always @(negedge iCLOCK) begin
        bit gv, gid, full;
        logic [1:0] exp_lock, exp_valid;
        if (!inRESET) begin
            check("m_rst_req", 64'(oMEMORY_REQ), 64'd0);
            check("m_rst_lock", 64'(oRQ_LOCK), 64'd0);
            check("m_rst_valid", 64'(oRQ_VALID), 64'd0);
            check("m_rst_err", 64'(oPROTOCOL_ERR), 64'd0);
        end else begin
            model_grant(gv, gid);
            full = (q.size() >= DEPTH);
            exp_lock[0] = iMEMORY_LOCK || full || (gv && gid == 1'b1);
            exp_lock[1] = iMEMORY_LOCK || full || (gv && gid == 1'b0);
            exp_valid = 2'b00;
            if (iMEMORY_VALID && q.size() > 0) exp_valid = (q[0] != 0) ? 2'b10 : 2'b01;
            check("m_req", 64'(oMEMORY_REQ), 64'(gv));
            check("m_lock", 64'(oRQ_LOCK), 64'(exp_lock));
            check("m_valid", 64'(oRQ_VALID), 64'(exp_valid));
            check("m_rdata", oRQ_DATA, iMEMORY_DATA);
            check("m_err", 64'(oPROTOCOL_ERR), 64'(err_m));
            if (gv) begin
                check("m_addr", 64'(oMEMORY_ADDR), 64'(gid ? iRQ_ADDR[63:32] : iRQ_ADDR[31:0]));
                check("m_wdata", 64'(oMEMORY_DATA), 64'(gid ? iRQ_DATA[63:32] : iRQ_DATA[31:0]));
                check("m_order", 64'(oMEMORY_ORDER), 64'(gid ? iRQ_ORDER[3:2] : iRQ_ORDER[1:0]));
                check("m_rw", 64'(oMEMORY_RW), 64'(gid ? iRQ_RW[1] : iRQ_RW[0]));
            end
        end
    end

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            iMEMORY_VALID = 1'b1;
            iMEMORY_DATA  = {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i * 3)};
            step();
        end
        iMEMORY_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        inRESET       = 1'b0;
        iRQ_REQ       = 2'b11;
        iRQ_ORDER     = 4'b1001;
        iRQ_RW        = 2'b10;
        iRQ_ADDR      = {32'h0000_3000, 32'h0000_2000};
        iRQ_DATA      = {32'hD0D0_D0D0, 32'h1010_1010};
        iMEMORY_LOCK  = 1'b1;
        iMEMORY_VALID = 1'b1;
        iMEMORY_DATA  = 64'h0;
        step(); step();
        #1;
        check("rst_req", 64'(oMEMORY_REQ), 64'd0);
        check("rst_lock", 64'(oRQ_LOCK), 64'd0);
        check("rst_valid", 64'(oRQ_VALID), 64'd0);
        check("rst_err", 64'(oPROTOCOL_ERR), 64'd0);
        iRQ_REQ = 2'b00; iMEMORY_LOCK = 1'b0; iMEMORY_VALID = 1'b0;
        step();
        inRESET = 1'b1;
        step();

        // lone instruction read
        iRQ_ADDR[31:0] = 32'h0000_1000;
        iRQ_REQ = 2'b01;
        #1;
        check("lone_addr", 64'(oMEMORY_ADDR), 64'h1000);
        check("lone_req", 64'(oMEMORY_REQ), 64'd1);
        step();
        iRQ_REQ = 2'b00;
        step(); step();
        iMEMORY_VALID = 1'b1;
        iMEMORY_DATA  = 64'h1122_3344_5566_7788;
        #1;
        check("lone_valid", 64'(oRQ_VALID), 64'h1);
        check("lone_data", oRQ_DATA, 64'h1122_3344_5566_7788);
        step();
        iMEMORY_VALID = 1'b0;

        // simultaneous requests
        iRQ_ADDR = {32'h0000_3000, 32'h0000_2000};
        iRQ_REQ  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bit want_d;
`ifdef MMU_MEMORY_ARBITER_RR_EN
            want_d = (i % 2 == 0);
`else
            want_d = 1'b1;
`endif
            #1;
            check("tie_lock", 64'(oRQ_LOCK), want_d ? 64'h1 : 64'h2);
            check("tie_addr", 64'(oMEMORY_ADDR), want_d ? 64'h3000 : 64'h2000);
            step();
        end
        iRQ_REQ = 2'b00;
        respond(4);

        // stalled data grant must not be preempted
        iRQ_ADDR[63:32] = 32'h0000_4000;
        iRQ_REQ = 2'b10;
        iMEMORY_LOCK = 1'b1;
        #1;
        check("hold_addr1", 64'(oMEMORY_ADDR), 64'h4000);
        check("hold_lock1", 64'(oRQ_LOCK), 64'h3);
        step();
        iRQ_REQ = 2'b11;
        #1;
        check("hold_addr2", 64'(oMEMORY_ADDR), 64'h4000);
        step();
        #1;
        check("hold_addr3", 64'(oMEMORY_ADDR), 64'h4000);
        step();
        iMEMORY_LOCK = 1'b0;
        #1;
        check("hold_addr4", 64'(oMEMORY_ADDR), 64'h4000);
        step();
        iRQ_REQ = 2'b01;
        #1;
        check("hold_inst", 64'(oMEMORY_ADDR), 64'h2000);
        step();
        iRQ_REQ = 2'b00;
        respond(2);

        // fill the tag FIFO
        iRQ_REQ = 2'b01;
        for (int i = 0; i < 8; i++) step();
        #1;
        check("full_lock", 64'(oRQ_LOCK), 64'h3);
        check("full_req", 64'(oMEMORY_REQ), 64'd0);
        iMEMORY_VALID = 1'b1;
        iMEMORY_DATA  = 64'hFEED;
        #1;
        check("full_pop_req", 64'(oMEMORY_REQ), 64'd0);
        check("full_pop_valid", 64'(oRQ_VALID), 64'h1);
        step();
        iMEMORY_VALID = 1'b0;
        #1;
        check("full_next_req", 64'(oMEMORY_REQ), 64'd1);
        step();
        iRQ_REQ = 2'b00;
        respond(8);

        // ordering I, D, I
        iRQ_REQ = 2'b01; step();
        iRQ_REQ = 2'b10; step();
        iRQ_REQ = 2'b01; step();
        iRQ_REQ = 2'b00;
        iMEMORY_VALID = 1'b1;
        #1; check("ord_0", 64'(oRQ_VALID), 64'h1); step();
        #1; check("ord_1", 64'(oRQ_VALID), 64'h2); step();
        #1; check("ord_2", 64'(oRQ_VALID), 64'h1); step();
        iMEMORY_VALID = 1'b0;

        // protocol error and mid-operation reset
        step();
        iMEMORY_VALID = 1'b1;
        #1;
        check("err_valid", 64'(oRQ_VALID), 64'h0);
        step();
        iMEMORY_VALID = 1'b0;
        #1;
        check("err_set", 64'(oPROTOCOL_ERR), 64'd1);
        iRQ_REQ = 2'b01;
        step(); step(); step();
        iRQ_REQ = 2'b00;
        inRESET = 1'b0;
        #1;
        check("rst_err_clr", 64'(oPROTOCOL_ERR), 64'd0);
        step();
        inRESET = 1'b1;
        step();
        iMEMORY_VALID = 1'b1;
        #1;
        check("post_rst_valid", 64'(oRQ_VALID), 64'h0);
        step();
        iMEMORY_VALID = 1'b0;
        #1;
        check("post_rst_err", 64'(oPROTOCOL_ERR), 64'd1);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
